// File: rtl/gate_sweep_n.sv
// gate_sweep_n: N-input gate with run-time op select and registered result.
// A built-in sweep engine steps all 2^N vectors, HOLD cycles each.
module gate_sweep_n #(
  parameter int N    = 2,
  parameter int HOLD = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x,
  input  logic [2:0]   op,
  input  logic         sweep_start,
  output logic         z,
  output logic         z_valid,
  output logic [N-1:0] sweep_vec,
  output logic         sweep_busy,
  output logic         sweep_done
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);
  localparam logic [N-1:0]  VEC_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    op_lat;
  logic [2:0]    op_eff;
  logic [N-1:0]  operand;
  logic          f_nxt;
  logic          last_hold;
  logic          last_vec;
  logic          start;

  assign last_hold = (hold_cnt == HOLD_MAX);
  assign last_vec  = (sweep_vec == VEC_MAX);
  assign start     = (state == IDLE) && sweep_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sweep_start) state_nxt = RUN;
      RUN:     if (last_hold && last_vec) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep uses the latched op and internal vector; otherwise live inputs
  always_comb begin
    sweep_busy = (state == RUN);
    sweep_done = (state == DONE);
    op_eff     = sweep_busy ? op_lat : op;
    operand    = sweep_busy ? sweep_vec : x;
  end

  always_comb begin
    f_nxt = 1'b0;
    case (op_eff)
      3'd0:    f_nxt = &operand;
      3'd1:    f_nxt = |operand;
      3'd2:    f_nxt = ^operand;
      3'd3:    f_nxt = ~&operand;
      3'd4:    f_nxt = ~|operand;
      3'd5:    f_nxt = ~^operand;
      3'd6:    f_nxt = operand[0];
      default: f_nxt = 1'b0;
    endcase
  end

  // z_valid marks the cycle after the vector's first evaluation edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z         <= 1'b0;
      z_valid   <= 1'b0;
      sweep_vec <= '0;
      hold_cnt  <= '0;
      op_lat    <= '0;
    end else begin
      z       <= f_nxt;
      z_valid <= (state == RUN) && (hold_cnt == '0);
      if (start) begin
        sweep_vec <= '0;
        hold_cnt  <= '0;
        op_lat    <= op;
      end else if (state == RUN) begin
        if (!last_hold) begin
          hold_cnt <= hold_cnt + 1'b1;
        end else begin
          hold_cnt  <= '0;
          sweep_vec <= last_vec ? '0 : sweep_vec + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_n.sv
// tb_gate_sweep_n: scoreboard bench for gate_sweep_n.
// Two instances: N=3/HOLD=3 and N=2/HOLD=1.
module tb_gate_sweep_n;

  localparam int NA = 3;
  localparam int HA = 3;
  localparam int NB = 2;
  localparam int HB = 1;
  localparam int MA = (1 << NA) * HA;
  localparam int MB = (1 << NB) * HB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    op = '0;
  logic [NA-1:0] xa = '0;
  logic [NB-1:0] xb = '0;
  logic          sa = 1'b0;
  logic          sb = 1'b0;
  logic          za, zva, ba, da;
  logic [NA-1:0] va;
  logic          zb, zvb, bb, db;
  logic [NB-1:0] vb;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int bcnt_a = 0;
  int bcnt_b = 0;
  logic qa[$];
  logic qb[$];
  int dqa[$];
  int dqb[$];

  gate_sweep_n #(.N(NA), .HOLD(HA)) u_a (
    .clk(clk), .rst(rst), .x(xa), .op(op), .sweep_start(sa),
    .z(za), .z_valid(zva), .sweep_vec(va),
    .sweep_busy(ba), .sweep_done(da)
  );

  gate_sweep_n #(.N(NB), .HOLD(HB)) u_b (
    .clk(clk), .rst(rst), .x(xb), .op(op), .sweep_start(sb),
    .z(zb), .z_valid(zvb), .sweep_vec(vb),
    .sweep_busy(bb), .sweep_done(db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate(input logic [2:0] o,
                                input logic [7:0] v,
                                input int n);
    int ones;
    ones = $countones(v);
    case (o)
      3'd0:    return ones == n;
      3'd1:    return ones != 0;
      3'd2:    return ones[0];
      3'd3:    return ones != n;
      3'd4:    return ones == 0;
      3'd5:    return !ones[0];
      3'd6:    return v[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (zva) begin
      chk("a_valid_expected", qa.size() != 0, 1);
      if (qa.size() != 0) chk("a_z", za, qa.pop_front());
    end
    if (ba) bcnt_a++;
    if (da) begin
      chk("a_busy_len", bcnt_a, MA);
      bcnt_a = 0;
      chk("a_done_expected", dqa.size() != 0, 1);
      if (dqa.size() != 0) chk("a_done_cyc", cyc, dqa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (zvb) begin
      chk("b_valid_expected", qb.size() != 0, 1);
      if (qb.size() != 0) chk("b_z", zb, qb.pop_front());
    end
    if (bb) bcnt_b++;
    if (db) begin
      chk("b_busy_len", bcnt_b, MB);
      bcnt_b = 0;
      chk("b_done_expected", dqb.size() != 0, 1);
      if (dqb.size() != 0) chk("b_done_cyc", cyc, dqb.pop_front());
    end
  end

  task automatic norm(input int iters, input bit directed);
    for (int i = 0; i < iters; i++) begin
      @(negedge clk);
      if (directed) begin
        op = 3'd0;
        xa = NA'(i);
        xb = NB'(i);
      end else begin
        op = 3'($urandom);
        xa = NA'($urandom);
        xb = NB'($urandom);
      end
      @(negedge clk);
      chk("a_norm_z", za, gate(op, 8'(xa), NA));
      chk("b_norm_z", zb, gate(op, 8'(xb), NB));
    end
  endtask

  task automatic sweep_a(input logic [2:0] o, input bit disturb);
    @(negedge clk);
    op = o;
    sa = 1'b1;
    for (int v = 0; v < (1 << NA); v++) qa.push_back(gate(o, 8'(v), NA));
    dqa.push_back(cyc + MA + 1);
    @(negedge clk);
    chk("a_busy_start", ba, 1);
    chk("a_vec_start", va, 0);
    for (int i = 1; i <= MA + 2; i++) begin
      sa = (disturb && i <= MA) ? 1'($urandom) : 1'b0;
      if (disturb) begin
        op = 3'($urandom);
        xa = NA'($urandom);
      end
      @(negedge clk);
    end
    chk("a_valid_count", qa.size(), 0);
    chk("a_done_seen", dqa.size(), 0);
  endtask

  task automatic sweep_b(input logic [2:0] o, input int reps);
    @(negedge clk);
    op = o;
    sb = 1'b1;
    for (int r = 0; r < reps; r++) begin
      for (int v = 0; v < (1 << NB); v++) qb.push_back(gate(o, 8'(v), NB));
      dqb.push_back(cyc + MB + 1 + r * (MB + 2));
    end
    repeat (reps * (MB + 2) - 1) @(negedge clk);
    sb = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_valid_count", qb.size(), 0);
    chk("b_done_seen", dqb.size(), 0);
  endtask

  task automatic abort_a();
    int t;
    t = 0;
    @(negedge clk);
    op = 3'd1;
    sa = 1'b1;
    for (int v = 0; v < (1 << NA); v++) qa.push_back(gate(3'd1, 8'(v), NA));
    dqa.push_back(cyc + MA + 1);
    @(negedge clk);
    sa = 1'b0;
    while (va != NA'(2) && t < 4 * MA) begin
      @(negedge clk);
      t++;
    end
    chk("a_reach_vec2", va, 2);
    #2 rst = 1'b1;
    #1;
    chk("a_rst_z", za, 0);
    chk("a_rst_zvalid", zva, 0);
    chk("a_rst_vec", va, 0);
    chk("a_rst_busy", ba, 0);
    chk("a_rst_done", da, 0);
    qa.delete();
    dqa.delete();
    bcnt_a = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (MA + 4) @(negedge clk);
    chk("a_idle_after_rst", ba, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #3;
    chk("a_reset_z", za, 0);
    chk("a_reset_zvalid", zva, 0);
    chk("a_reset_vec", va, 0);
    chk("a_reset_busy", ba, 0);
    chk("a_reset_done", da, 0);
    chk("b_reset_z", zb, 0);
    chk("b_reset_zvalid", zvb, 0);
    chk("b_reset_vec", vb, 0);
    chk("b_reset_busy", bb, 0);
    chk("b_reset_done", db, 0);
    @(negedge clk);
    rst = 1'b0;
    norm(4, 1'b1);
    norm(24, 1'b0);
    sweep_a(3'd0, 1'b0);
    sweep_a(3'd2, 1'b0);
    sweep_a(3'd0, 1'b1);
    for (int i = 0; i < 4; i++) sweep_a(3'($urandom_range(0, 7)), 1'b1);
    sweep_b(3'd3, 1);
    sweep_b(3'd0, 2);
    for (int i = 0; i < 4; i++) sweep_b(3'($urandom_range(0, 7)), 1 + i % 2);
    abort_a();
    sweep_a(3'd5, 1'b0);
    norm(10, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
